// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// RF_ADDR_WIDTH / RF_DATA_WIDTH : default address and data widths.
// wb_req_t                      : one buffered writeback request {addr, data}.
package rf_pkg;

   localparam int RF_ADDR_WIDTH = 4;
   localparam int RF_DATA_WIDTH = 32;

   typedef struct packed {
      logic [RF_ADDR_WIDTH-1:0] addr;
      logic [RF_DATA_WIDTH-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/rf_wb_arb_if.sv
// Writeback request bus from the two producers (A = ALU, B = LSU).
// Ports:
//   iAValid/iAAddr/iAData, iBValid/iBAddr/iBData : requests from the sources
//   oAReady/oBReady                              : per-source FIFO not full
// Modports: master = producer side, slave = arbiter side.
interface rf_wb_arb_if
   import rf_pkg::*;
#(
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int DATA_WIDTH = RF_DATA_WIDTH
);

   logic                  iAValid;
   logic [ADDR_WIDTH-1:0] iAAddr;
   logic [DATA_WIDTH-1:0] iAData;
   logic                  oAReady;
   logic                  iBValid;
   logic [ADDR_WIDTH-1:0] iBAddr;
   logic [DATA_WIDTH-1:0] iBData;
   logic                  oBReady;

   modport master (
      output iAValid, iAAddr, iAData, iBValid, iBAddr, iBData,
      input  oAReady, oBReady
   );

   modport slave (
      input  iAValid, iAAddr, iAData, iBValid, iBAddr, iBData,
      output oAReady, oBReady
   );

endinterface

// File: rtl/rf_wb_fifo.sv
// Two-entry in-order FIFO holding writeback requests for one source.
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset
//   push_valid  : source request; accepted when push_valid && ready
//   push_data   : request payload
//   ready       : registered "count < 2"; low during reset
//   pop         : arbiter grant, removes the head entry
//   head        : oldest entry
//   head_valid  : FIFO not empty
module rf_wb_fifo
   import rf_pkg::*;
#(
   parameter type T = wb_req_t
) (
   input  logic clk,
   input  logic rstn,
   input  logic push_valid,
   input  T     push_data,
   output logic ready,
   input  logic pop,
   output T     head,
   output logic head_valid
);

   T           mem [2];
   logic [1:0] cnt;
   logic [1:0] cnt_nxt;
   logic       wptr;
   logic       rptr;
   logic       push;
   logic       pop_ok;

   // ready is registered, so a full FIFO never accepts even if it pops
   // on the same edge.
   assign push       = push_valid && ready;
   assign pop_ok     = pop && (cnt != 2'd0);
   assign head       = mem[rptr];
   assign head_valid = (cnt != 2'd0);

   always_comb begin
      cnt_nxt = cnt;
      if (push && !pop_ok)
         cnt_nxt = cnt + 2'd1;
      else if (!push && pop_ok)
         cnt_nxt = cnt - 2'd1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt   <= 2'd0;
         wptr  <= 1'b0;
         rptr  <= 1'b0;
         ready <= 1'b0;
      end else begin
         cnt   <= cnt_nxt;
         wptr  <= wptr ^ push;
         rptr  <= rptr ^ pop_ok;
         ready <= (cnt_nxt != 2'd2);
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wptr] <= push_data;
   end

endmodule

// File: rtl/rf_wb_arb.sv
// Register-file writeback arbiter: two buffered sources, round-robin
// grant, one registered RF write port, register 0 hardwired to zero.
// Ports:
//   clk, rstn                  : clock, asynchronous active-low reset
//   bus (rf_wb_arb_if.slave)   : A/B writeback requests and readies
//   iStall                     : suppresses all grants while high
//   oWrEn/oWrAddr/oWrData      : registered RF write port
//   iRdAddrA/B, iRfDataA/B     : RF read addresses and raw RF read data
//   oRdDataA/B                 : read data delivered to decode
// Build option: define RF_WB_FWD_EN to bypass the write in flight onto
// the read ports when the addresses match.
module rf_wb_arb
   import rf_pkg::*;
#(
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rstn,
   rf_wb_arb_if.slave            bus,
   input  logic                  iStall,
   output logic                  oWrEn,
   output logic [ADDR_WIDTH-1:0] oWrAddr,
   output logic [DATA_WIDTH-1:0] oWrData,
   input  logic [ADDR_WIDTH-1:0] iRdAddrA,
   input  logic [ADDR_WIDTH-1:0] iRdAddrB,
   input  logic [DATA_WIDTH-1:0] iRfDataA,
   input  logic [DATA_WIDTH-1:0] iRfDataB,
   output logic [DATA_WIDTH-1:0] oRdDataA,
   output logic [DATA_WIDTH-1:0] oRdDataB
);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } req_t;

   localparam logic RR_A = 1'b0;
   localparam logic RR_B = 1'b1;

   req_t a_head_p0;
   req_t b_head_p0;
   req_t sel_p0;
   logic a_vld_p0;
   logic b_vld_p0;
   logic gnt_a_p0;
   logic gnt_b_p0;
   logic gnt_p0;
   logic rr_ptr;

   rf_wb_fifo #(.T(req_t)) u_fifo_a (
      .clk        (clk),
      .rstn       (rstn),
      .push_valid (bus.iAValid),
      .push_data  ({bus.iAAddr, bus.iAData}),
      .ready      (bus.oAReady),
      .pop        (gnt_a_p0),
      .head       (a_head_p0),
      .head_valid (a_vld_p0)
   );

   rf_wb_fifo #(.T(req_t)) u_fifo_b (
      .clk        (clk),
      .rstn       (rstn),
      .push_valid (bus.iBValid),
      .push_data  ({bus.iBAddr, bus.iBData}),
      .ready      (bus.oBReady),
      .pop        (gnt_b_p0),
      .head       (b_head_p0),
      .head_valid (b_vld_p0)
   );

   // ---- p0: FIFO heads, grant decision ----
   // A lone valid head always wins; with both valid, rr_ptr decides.
   assign gnt_a_p0 = !iStall && a_vld_p0 && (!b_vld_p0 || (rr_ptr == RR_A));
   assign gnt_b_p0 = !iStall && b_vld_p0 && (!a_vld_p0 || (rr_ptr == RR_B));
   assign gnt_p0   = gnt_a_p0 || gnt_b_p0;
   assign sel_p0   = gnt_b_p0 ? b_head_p0 : a_head_p0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         rr_ptr <= RR_A;
      else if (gnt_a_p0)
         rr_ptr <= RR_B;
      else if (gnt_b_p0)
         rr_ptr <= RR_A;
   end

   // ---- p1: registered RF write port ----
   // Address-0 entries are popped but never written; the port holds its
   // last real write whenever nothing is written.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         oWrEn   <= 1'b0;
         oWrAddr <= '0;
         oWrData <= '0;
      end else begin
         oWrEn <= gnt_p0 && (sel_p0.addr != '0);
         if (gnt_p0 && (sel_p0.addr != '0)) begin
            oWrAddr <= sel_p0.addr;
            oWrData <= sel_p0.data;
         end
      end
   end

   // Read ports: register 0 reads as zero; optional bypass of the write
   // currently on the RF write port.
   always_comb begin
      oRdDataA = iRfDataA;
      oRdDataB = iRfDataB;
`ifdef RF_WB_FWD_EN
      if (oWrEn && (oWrAddr == iRdAddrA))
         oRdDataA = oWrData;
      if (oWrEn && (oWrAddr == iRdAddrB))
         oRdDataB = oWrData;
`endif
      if (iRdAddrA == '0)
         oRdDataA = '0;
      if (iRdAddrB == '0)
         oRdDataB = '0;
   end

endmodule

// File: tb/tb_rf_wb_arb.sv
// Testbench for rf_wb_arb: directed writeback sequences, expected RF
// writes queued in arbitration order and compared by a monitor.
module tb_rf_wb_arb;

   logic        clk;
   logic        rstn;
   logic        iStall;
   logic        oWrEn;
   logic [3:0]  oWrAddr;
   logic [31:0] oWrData;
   logic [3:0]  iRdAddrA;
   logic [3:0]  iRdAddrB;
   logic [31:0] iRfDataA;
   logic [31:0] iRfDataB;
   logic [31:0] oRdDataA;
   logic [31:0] oRdDataB;

   int n_chk;
   int n_fail;

   logic [35:0] exp_q[$];
   logic [35:0] mon_e;

   rf_wb_arb_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

   rf_wb_arb #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .bus      (bus),
      .iStall   (iStall),
      .oWrEn    (oWrEn),
      .oWrAddr  (oWrAddr),
      .oWrData  (oWrData),
      .iRdAddrA (iRdAddrA),
      .iRdAddrB (iRdAddrB),
      .iRfDataA (iRfDataA),
      .iRfDataB (iRfDataB),
      .oRdDataA (oRdDataA),
      .oRdDataB (oRdDataB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic drive_a(input logic [3:0] a, input logic [31:0] d, input bit expect_wr);
      bus.iAValid = 1'b1;
      bus.iAAddr  = a;
      bus.iAData  = d;
      if (expect_wr) exp_q.push_back({a, d});
   endtask

   task automatic drive_b(input logic [3:0] a, input logic [31:0] d, input bit expect_wr);
      bus.iBValid = 1'b1;
      bus.iBAddr  = a;
      bus.iBData  = d;
      if (expect_wr) exp_q.push_back({a, d});
   endtask

   task automatic quiet();
      bus.iAValid = 1'b0;
      bus.iBValid = 1'b0;
   endtask

   // Scoreboard monitor: every RF write must match the next expected one.
   always @(negedge clk) begin
      if (rstn === 1'b1 && oWrEn === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: got write addr 0x%0h data 0x%0h, expected none at %0t",
                     oWrAddr, oWrData, $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("sb_addr", 64'(oWrAddr), 64'(mon_e[35:32]));
            check("sb_data", 64'(oWrData), 64'(mon_e[31:0]));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0;
      n_fail = 0;
      rstn = 1'b0;
      iStall = 1'b0;
      bus.iAValid = 1'b0; bus.iAAddr = '0; bus.iAData = '0;
      bus.iBValid = 1'b0; bus.iBAddr = '0; bus.iBData = '0;
      iRdAddrA = '0; iRdAddrB = '0; iRfDataA = '0; iRfDataB = '0;

      // Reset state
      idle(3);
      check("rst_wren", 64'(oWrEn), 64'd0);
      check("rst_wraddr", 64'(oWrAddr), 64'd0);
      check("rst_wrdata", 64'(oWrData), 64'd0);
      check("rst_areadyy", 64'(bus.oAReady), 64'd0);
      check("rst_bready", 64'(bus.oBReady), 64'd0);
      rstn = 1'b1;
      tick();
      check("rel_aready", 64'(bus.oAReady), 64'd1);
      check("rel_bready", 64'(bus.oBReady), 64'd1);

      // Single A write: visible one edge after the accept edge, one cycle
      drive_a(4'd3, 32'hDEADBEEF, 1);
      tick();
      quiet();
      check("lat_wren_early", 64'(oWrEn), 64'd0);
      tick();
      check("lat_wren", 64'(oWrEn), 64'd1);
      check("lat_addr", 64'(oWrAddr), 64'd3);
      check("lat_data", 64'(oWrData), 64'hDEADBEEF);
      tick();
      check("lat_one_cycle", 64'(oWrEn), 64'd0);
      idle(2);

      // B-only write leaves rr pointing at A
      drive_b(4'd9, 32'h99, 1);
      tick();
      quiet();
      idle(3);

      // Simultaneous pair with rr=A: A first then B
      drive_a(4'd5, 32'h11, 1);
      drive_b(4'd6, 32'h22, 1);
      tick();
      quiet();
      tick();
      check("pair1_first", 64'(oWrAddr), 64'd5);
      tick();
      check("pair1_second", 64'(oWrAddr), 64'd6);
      check("pair1_second_en", 64'(oWrEn), 64'd1);
      idle(2);

      // A-only grant leaves rr at B; next pair grants B first
      drive_a(4'd1, 32'h1111, 1);
      tick();
      quiet();
      idle(3);
      drive_b(4'd3, 32'h3333, 1);
      drive_a(4'd2, 32'h2222, 1);
      tick();
      quiet();
      tick();
      check("pair2_first", 64'(oWrAddr), 64'd3);
      tick();
      check("pair2_second", 64'(oWrAddr), 64'd2);
      idle(2);

      // Stall: accept two, hold the third, then drain in order
      iStall = 1'b1;
      drive_a(4'd1, 32'hA1, 1);
      tick();
      drive_a(4'd2, 32'hA2, 1);
      tick();
      drive_a(4'd4, 32'hA4, 1);
      check("stall_full_ready", 64'(bus.oAReady), 64'd0);
      tick();
      check("stall_ready_held", 64'(bus.oAReady), 64'd0);
      check("stall_no_wr", 64'(oWrEn), 64'd0);
      tick();
      check("stall_no_wr2", 64'(oWrEn), 64'd0);
      iStall = 1'b0;
      tick();
      check("unstall_wren", 64'(oWrEn), 64'd1);
      check("unstall_addr", 64'(oWrAddr), 64'd1);
      check("unstall_ready", 64'(bus.oAReady), 64'd1);
      tick();
      quiet();
      idle(4);

      // Address 0: popped and dropped; reads of r0 return zero
      drive_a(4'd0, 32'hFFFF, 0);
      tick();
      quiet();
      tick();
      check("r0_drop_wren", 64'(oWrEn), 64'd0);
      iRdAddrA = 4'd0; iRfDataA = 32'hFFFFFFFF;
      iRdAddrB = 4'd0; iRfDataB = 32'h1234;
      #1;
      check("r0_read_a", 64'(oRdDataA), 64'd0);
      check("r0_read_b", 64'(oRdDataB), 64'd0);
      iRdAddrA = 4'd5; iRfDataA = 32'h55;
      #1;
      check("read_pass_a", 64'(oRdDataA), 64'h55);
      drive_a(4'd8, 32'h88, 1);
      tick();
      quiet();
      idle(3);

      // Write in flight vs. read ports
      drive_a(4'd7, 32'hCAFE, 1);
      tick();
      quiet();
      tick();
      iRdAddrA = 4'd7; iRfDataA = 32'h1;
      iRdAddrB = 4'd7; iRfDataB = 32'h2;
      #1;
`ifdef RF_WB_FWD_EN
      check("fwd_read_a", 64'(oRdDataA), 64'hCAFE);
      check("fwd_read_b", 64'(oRdDataB), 64'hCAFE);
`else
      check("fwd_read_a", 64'(oRdDataA), 64'h1);
      check("fwd_read_b", 64'(oRdDataB), 64'h2);
`endif
      tick();
      check("fwd_idle_read_a", 64'(oRdDataA), 64'h1);
      iRdAddrA = '0; iRdAddrB = '0;
      idle(2);

      // Reset with both FIFOs full (rr=B, so B head goes out first)
      iStall = 1'b1;
      drive_a(4'd10, 32'hA10, 0);
      drive_b(4'd12, 32'hB12, 0);
      tick();
      drive_a(4'd11, 32'hA11, 0);
      drive_b(4'd13, 32'hB13, 0);
      tick();
      quiet();
      check("full_aready", 64'(bus.oAReady), 64'd0);
      check("full_bready", 64'(bus.oBReady), 64'd0);
      iStall = 1'b0;
      tick();
      check("prerst_wren", 64'(oWrEn), 64'd1);
      check("prerst_addr", 64'(oWrAddr), 64'd12);
      #1;
      rstn = 1'b0;
      #1;
      check("async_rst_wren", 64'(oWrEn), 64'd0);
      check("async_rst_addr", 64'(oWrAddr), 64'd0);
      check("async_rst_aready", 64'(bus.oAReady), 64'd0);
      idle(2);
      rstn = 1'b1;
      tick();
      check("rerel_aready", 64'(bus.oAReady), 64'd1);
      check("rerel_bready", 64'(bus.oBReady), 64'd1);
      for (int i = 0; i < 6; i++) begin
         check("post_rst_no_wr", 64'(oWrEn), 64'd0);
         tick();
      end

      // rr back at A after reset
      drive_a(4'd14, 32'hE, 1);
      drive_b(4'd15, 32'hF, 1);
      tick();
      quiet();
      tick();
      check("rr_after_rst", 64'(oWrAddr), 64'd14);
      idle(4);

      check("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
